// File: rtl/addr_sweep_ctrl.sv
// addr_sweep_ctrl: walks a rows x cols window of a tensor buffer and streams
// one address per beat over a valid/ready handshake. A start strobe in IDLE
// latches the window, RUN issues the beats, DONE raises a one-cycle pulse.
module addr_sweep_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [CNT_WIDTH-1:0]  num_rows,
    input  logic [CNT_WIDTH-1:0]  num_cols,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Sweep configuration captured on an accepted start; inputs are ignored
    // afterwards so the upstream FSM may change them freely during RUN.
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [CNT_WIDTH-1:0]  r_rows;
    logic [CNT_WIDTH-1:0]  r_cols;

    // Position within the sweep. r_row_base accumulates the stride so no
    // multiplier is needed; it wraps silently modulo 2**ADDR_WIDTH.
    logic [CNT_WIDTH-1:0]  r_row;
    logic [CNT_WIDTH-1:0]  r_col;
    logic [ADDR_WIDTH-1:0] r_row_base;

    logic w_start_acc;
    logic w_cfg_empty;
    logic w_xfer;
    logic w_col_end;
    logic w_row_end;
    logic w_last_beat;
    logic [ADDR_WIDTH-1:0] w_col_ext;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_cfg_empty = (num_rows == '0) || (num_cols == '0);
    assign w_xfer      = addr_valid && addr_ready;
    assign w_col_end   = (r_col == (r_cols - CNT_ONE));
    assign w_row_end   = (r_row == (r_rows - CNT_ONE));
    assign w_last_beat = w_col_end && w_row_end;
    assign w_col_ext   = ADDR_WIDTH'(r_col);

    // State register; reset aborts any sweep in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and outputs; outputs decode from state only so the beat
    // presented never depends on addr_ready (no retraction possible).
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        addr_valid  = 1'b0;
        last        = 1'b0;
        addr        = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_empty ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                addr_valid = 1'b1;
                addr       = r_row_base + w_col_ext;
                last       = w_last_beat;
                if (addr_ready && w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Configuration capture and row/column walk, advancing one element per
    // accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride   <= '0;
            r_rows     <= '0;
            r_cols     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
        end else if (w_start_acc) begin
            r_stride   <= row_stride;
            r_rows     <= num_rows;
            r_cols     <= num_cols;
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= base_addr;
        end else if (w_xfer) begin
            if (!w_col_end) begin
                r_col <= r_col + CNT_ONE;
            end else begin
                r_col      <= '0;
                r_row      <= r_row + CNT_ONE;
                r_row_base <= r_row_base + r_stride;
            end
        end
    end

endmodule

// File: tb/tb_addr_sweep_ctrl.sv
// Directed bench for addr_sweep_ctrl: expected beats are queued when a sweep
// is launched and popped as the DUT transfers them.
module tb_addr_sweep_ctrl;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] row_stride;
    logic [CW-1:0] num_rows;
    logic [CW-1:0] num_cols;
    logic          busy;
    logic          done;
    logic          addr_valid;
    logic          addr_ready;
    logic [AW-1:0] addr;
    logic          last;

    addr_sweep_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .num_rows   (num_rows),
        .num_cols   (num_cols),
        .busy       (busy),
        .done       (done),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr       (addr),
        .last       (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int q_addr[$];
    int q_last[$];

    int done_cnt, beats, valid_cycles;
    int first_cyc, last_cyc, done_cyc;
    bit hold_pending;
    logic [AW-1:0] hold_addr;
    logic hold_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_track();
        done_cnt = 0; beats = 0; valid_cycles = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        hold_pending = 0;
    endtask

    // Examine the current cycle (outputs settled, inputs applied), then
    // advance across one rising edge and settle 1 time unit past it.
    task automatic tick();
        int ea, el;
        if (hold_pending) begin
            chk("hold_valid", addr_valid, 1);
            chk("hold_addr", addr, hold_addr);
            chk("hold_last", last, hold_last);
            hold_pending = 0;
        end
        if (addr_valid) begin
            valid_cycles++;
            chk("busy_in_run", busy, 1);
            if (addr_ready) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_beat", 0, 1);
                end else begin
                    ea = q_addr.pop_front();
                    el = q_last.pop_front();
                    chk("beat_addr", addr, ea);
                    chk("beat_last", last, el);
                    if (el != 0) last_cyc = cyc;
                end
                if (first_cyc < 0) first_cyc = cyc;
                beats++;
            end else begin
                hold_pending = 1;
                hold_addr = addr;
                hold_last = last;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_in_done", busy, 1);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_expect(input int base, input int stride, input int rows, input int cols);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                q_addr.push_back((base + r * stride + c) & ((1 << AW) - 1));
                q_last.push_back((r == rows - 1 && c == cols - 1) ? 1 : 0);
            end
    endtask

    // rmode 0: ready held high; rmode 1: ready toggles 1,0,1,0...
    // inject: pulse start with a different config during RUN.
    task automatic sweep(input int base, input int stride, input int rows, input int cols,
                         input int rmode, input bit inject);
        int start_cyc;
        int k;
        clear_track();
        push_expect(base, stride, rows, cols);
        base_addr  = AW'(base);
        row_stride = AW'(stride);
        num_rows   = CW'(rows);
        num_cols   = CW'(cols);
        addr_ready = 1'b1;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
        // Config changes after start must not disturb the sweep.
        base_addr  = 4'd9;
        row_stride = 4'd7;
        num_rows   = 4'd1;
        num_cols   = 4'd1;
        k = 0;
        while (done_cnt == 0 && k < 100) begin
            addr_ready = (rmode == 0) ? 1'b1 : ((k % 2) == 0);
            start      = (inject && k == 1) ? 1'b1 : 1'b0;
            tick();
            k++;
        end
        start      = 1'b0;
        addr_ready = 1'b1;
        chk("done_seen", (done_cnt != 0), 1);
        chk("beat_count", beats, rows * cols);
        chk("queue_drained", q_addr.size(), 0);
        if (rows * cols > 0) begin
            chk("done_after_last", done_cyc, last_cyc + 1);
            if (rmode == 0) chk("first_beat_latency", first_cyc, start_cyc + 1);
        end else begin
            chk("empty_no_valid", valid_cycles, 0);
            chk("empty_done_latency", done_cyc, start_cyc + 1);
        end
        tick();
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("single_done", done_cnt, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        row_stride = '0;
        num_rows   = '0;
        num_cols   = '0;
        addr_ready = 1'b0;
        clear_track();
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_last", last, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 basic sweep, ready always high
        sweep(2, 4, 2, 3, 0, 0);
        // T2 same sweep with ready toggling
        sweep(2, 4, 2, 3, 1, 0);
        // T3 empty sweeps
        sweep(5, 1, 0, 3, 0, 0);
        sweep(5, 1, 2, 0, 0, 0);
        // T4 address wrap
        sweep(14, 3, 2, 3, 0, 0);
        // T5 start during RUN ignored
        sweep(1, 5, 2, 2, 0, 1);
        // Single-element sweep: first beat is also last
        sweep(7, 0, 1, 1, 0, 0);

        // T6 reset mid-sweep after two beats
        clear_track();
        push_expect(5, 2, 3, 3);
        base_addr  = 4'd5;
        row_stride = 4'd2;
        num_rows   = 4'd3;
        num_cols   = 4'd3;
        addr_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        tick();
        tick();
        chk("t6_two_beats", beats, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_valid", addr_valid, 0);
        chk("t6_addr", addr, 0);
        chk("t6_last", last, 0);
        chk("t6_done", done, 0);
        q_addr.delete();
        q_last.delete();
        clear_track();
        tick();
        tick();
        chk("t6_no_done", done_cnt, 0);
        #2;
        rst_n = 1'b1;
        tick();
        sweep(5, 2, 3, 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
